// File: rtl/pipe_burst_stats.sv
// Purpose: groups consecutive valid samples into bursts and reports count/sum/max/min per burst.
// Latency: report registers on the closing edge (gap edge, or the edge of the MAX_LEN-th sample).
// Backpressure: one-entry report buffer; a summary closing while the buffer is held is dropped (sticky drop_flag).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid, in_data     sample stream from the multiply-add pipe, no upstream backpressure
//   out_ready             consumer accepts the buffered report this cycle
//   clr_drop              synchronous clear of drop_flag (a same-cycle drop wins)
//   out_valid             report buffer holds an unaccepted summary
//   out_count/sum/max/min burst summary, stable while out_valid && !out_ready
//   drop_flag             sticky: a completed summary was discarded
module pipe_burst_stats #(
    parameter int  DATA_W  = 8,
    parameter int  MAX_LEN = 16,
    localparam int CNT_W   = $clog2(MAX_LEN) + 1,
    localparam int SUM_W   = DATA_W + $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    input  logic              clr_drop,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_count,
    output logic [SUM_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic              drop_flag
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  acc_count, acc_count_nxt, upd_count, rpt_count;
    logic [SUM_W-1:0]  acc_sum, acc_sum_nxt, upd_sum, rpt_sum;
    logic [DATA_W-1:0] acc_max, acc_max_nxt, upd_max, rpt_max;
    logic [DATA_W-1:0] acc_min, acc_min_nxt, upd_min, rpt_min;
    logic              close, close_cap, load, drop;

    always_comb begin
        state_nxt     = state;
        acc_count_nxt = acc_count;
        acc_sum_nxt   = acc_sum;
        acc_max_nxt   = acc_max;
        acc_min_nxt   = acc_min;

        // Running values including the current sample.
        upd_count = acc_count + CNT_W'(1);
        upd_sum   = acc_sum + SUM_W'(in_data);
        upd_max   = (in_data > acc_max) ? in_data : acc_max;
        upd_min   = (in_data < acc_min) ? in_data : acc_min;

        close_cap = (state == ACC) && in_valid && (acc_count == CNT_W'(MAX_LEN - 1));
        close     = close_cap || ((state == ACC) && !in_valid);

        // A cap close reports the burst including the closing sample;
        // a gap close reports what has been accumulated.
        rpt_count = close_cap ? upd_count : acc_count;
        rpt_sum   = close_cap ? upd_sum   : acc_sum;
        rpt_max   = close_cap ? upd_max   : acc_max;
        rpt_min   = close_cap ? upd_min   : acc_min;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt     = ACC;
                    acc_count_nxt = CNT_W'(1);
                    acc_sum_nxt   = SUM_W'(in_data);
                    acc_max_nxt   = in_data;
                    acc_min_nxt   = in_data;
                end
            end
            ACC: begin
                if (close) begin
                    state_nxt = IDLE;
                end else begin
                    acc_count_nxt = upd_count;
                    acc_sum_nxt   = upd_sum;
                    acc_max_nxt   = upd_max;
                    acc_min_nxt   = upd_min;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // The buffer can take a new summary if empty or being drained this edge.
        load = close && (!out_valid || out_ready);
        drop = close && out_valid && !out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_count <= '0;
            acc_sum   <= '0;
            acc_max   <= '0;
            acc_min   <= '0;
        end else begin
            state     <= state_nxt;
            acc_count <= acc_count_nxt;
            acc_sum   <= acc_sum_nxt;
            acc_max   <= acc_max_nxt;
            acc_min   <= acc_min_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_count <= '0;
            out_sum   <= '0;
            out_max   <= '0;
            out_min   <= '0;
            drop_flag <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_count <= rpt_count;
                out_sum   <= rpt_sum;
                out_max   <= rpt_max;
                out_min   <= rpt_min;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            if (drop) begin
                drop_flag <= 1'b1;
            end else if (clr_drop) begin
                drop_flag <= 1'b0;
            end
        end
    end

endmodule
